// File: rtl/counter_sweep_ctrl_pkg.sv
// Shared definitions for the counter sweep controller: FSM state codes,
// counting-direction constants and the start-argument validity rule.
package counter_sweep_pkg;

    // FSM state encoding, kept as plain constants so legacy code can decode it.
    localparam logic [1:0] ST_IDLE = 2'd0;  // counter parked at lo, waiting for start
    localparam logic [1:0] ST_ARM  = 2'd1;  // one cycle: release the load, seed the checker
    localparam logic [1:0] ST_UP   = 2'd2;  // counting towards hi
    localparam logic [1:0] ST_DOWN = 2'd3;  // counting back towards lo

    // Value driven on cnt_up_down.
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // A run may start only with a non-empty sweep count and a non-empty range
    // that lies entirely below the counter's wrap point.
    function automatic logic sweep_args_ok(
        input int unsigned lo,
        input int unsigned hi,
        input int unsigned sweeps,
        input int unsigned wrap
    );
        return (sweeps != 0) && (hi > lo) && (hi <= wrap);
    endfunction

endpackage

// File: rtl/counter_sweep_ctrl_if.sv
// Bundle between the comparator control logic, the sweep controller and the
// up/down counter. The controller takes the master view: it consumes the
// start/abort command and the counter read-back, and drives the status and
// counter command signals. The slave view is the mirror image, used by
// whatever sits on the other side (control logic plus counter).
interface counter_sweep_ctrl_if #(
    parameter int WIDTH   = 8,
    parameter int SWEEP_W = 4
);

    // Command side
    logic               start;
    logic               abort;
    logic [WIDTH-1:0]   lo_in;
    logic [WIDTH-1:0]   hi_in;
    logic [SWEEP_W-1:0] sweeps_in;

    // Status side
    logic               busy;
    logic               done;
    logic               err;

    // Counter side
    logic               cnt_load;
    logic [WIDTH-1:0]   cnt_data;
    logic               cnt_up_down;
    logic [WIDTH-1:0]   cnt_wrap;
    logic [WIDTH-1:0]   cnt_count;

    modport master (
        input  start, abort, lo_in, hi_in, sweeps_in, cnt_count,
        output busy, done, err, cnt_load, cnt_data, cnt_up_down, cnt_wrap
    );

    modport slave (
        output start, abort, lo_in, hi_in, sweeps_in, cnt_count,
        input  busy, done, err, cnt_load, cnt_data, cnt_up_down, cnt_wrap
    );

endinterface

// File: rtl/counter_sweep_ctrl_seq_checker.sv
// Expected-count tracker for the sweep controller. It is seeded with the low
// bound when the run is armed, then follows the direction the controller is
// driving, one step per cycle. Whenever it is stepping, the counter's
// read-back must equal the tracked value; otherwise mismatch is raised.
module counter_seq_checker
    import counter_sweep_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic [WIDTH-1:0] init_val,
    input  logic             step,
    input  logic             dir,
    input  logic [WIDTH-1:0] count,
    output logic             mismatch
);

    logic [WIDTH-1:0] exp_q;

    // Track the value the counter should show in the current cycle.
    // NOTE: exp_q is an ordinary register, not a memory, so it takes a reset
    // value; without it a mid-run reset would leave a stale expectation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_q <= '0;
        end else if (init) begin
            exp_q <= init_val;
        end else if (step) begin
            exp_q <= (dir == DIR_UP) ? exp_q + WIDTH'(1) : exp_q - WIDTH'(1);
        end
    end

    // Compare only while the counter is free-running under our control.
    assign mismatch = step && (count != exp_q);

endmodule

// File: rtl/counter_sweep_ctrl.sv
// Sweep controller for the 8-bit up/down counter.
// Accepts a start request with bounds lo/hi and a sweep count N, then drives
// the counter through N ping-pong sweeps lo->hi->lo, reversing direction one
// cycle before each bound so the counter lands exactly on it. Every count the
// counter returns while sweeping is compared with an internally tracked
// expectation; a mismatch ends the run with err and done. Between runs the
// counter is held loaded with lo (parked).
module counter_sweep_ctrl
    import counter_sweep_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int WRAP_VALUE = 99,
    parameter int SWEEP_W    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    counter_sweep_ctrl_if.master bus
);

    localparam logic [WIDTH-1:0] WRAP = WIDTH'(WRAP_VALUE);

    // Run state and latched arguments
    logic [1:0]         state_q;
    logic [WIDTH-1:0]   lo_q;
    logic [WIDTH-1:0]   hi_q;
    logic [SWEEP_W-1:0] rem_q;      // sweeps still to finish, including the current one

    // Registered outputs
    logic               busy_q;
    logic               done_q;
    logic               err_q;
    logic               load_q;
    logic [WIDTH-1:0]   data_q;
    logic               dir_q;

    // Decodes of the current cycle
    logic               start_ok;
    logic               at_top;
    logic               at_bottom;
    logic               chk_init;
    logic               chk_step;
    logic               mismatch;

    // Decode argument validity, turn-around points and checker controls.
    always_comb begin
        start_ok  = sweep_args_ok(32'(bus.lo_in), 32'(bus.hi_in),
                                  32'(bus.sweeps_in), 32'(WRAP));
        // Reversal is requested one count early: the counter still takes
        // one step in the old direction on the edge that flips cnt_up_down.
        at_top    = (bus.cnt_count == hi_q - WIDTH'(1));
        at_bottom = (bus.cnt_count == lo_q + WIDTH'(1));
        chk_init  = (state_q == ST_ARM);
        chk_step  = (state_q == ST_UP) || (state_q == ST_DOWN);
    end

    counter_seq_checker #(
        .WIDTH    (WIDTH)
    ) u_checker (
        .clk      (clk),
        .rst      (rst),
        .init     (chk_init),
        .init_val (lo_q),
        .step     (chk_step),
        .dir      (dir_q),
        .count    (bus.cnt_count),
        .mismatch (mismatch)
    );

    // Sweep FSM: argument capture, direction control, run termination.
    // NOTE: every register here uses non-blocking assignment so all of them
    // update together from pre-edge values; later assignments in the same
    // branch deliberately override earlier defaults.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            lo_q    <= '0;
            hi_q    <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            load_q  <= 1'b1;
            data_q  <= '0;
            dir_q   <= DIR_UP;
        end else begin
            done_q <= 1'b0;

            if (bus.abort) begin
                // Cancel from any state: park at lo quietly, keep err as is.
                state_q <= ST_IDLE;
                load_q  <= 1'b1;
                data_q  <= lo_q;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        load_q <= 1'b1;
                        data_q <= lo_q;
                        if (bus.start) begin
                            if (start_ok) begin
                                lo_q    <= bus.lo_in;
                                hi_q    <= bus.hi_in;
                                rem_q   <= bus.sweeps_in;
                                data_q  <= bus.lo_in;
                                err_q   <= 1'b0;
                                busy_q  <= 1'b1;
                                state_q <= ST_ARM;
                            end else begin
                                // Rejected request: report and stay parked.
                                err_q  <= 1'b1;
                                done_q <= 1'b1;
                            end
                        end
                    end

                    ST_ARM: begin
                        // Counter now holds lo; let it run upwards.
                        load_q  <= 1'b0;
                        dir_q   <= DIR_UP;
                        state_q <= ST_UP;
                    end

                    ST_UP: begin
                        if (mismatch) begin
                            state_q <= ST_IDLE;
                            load_q  <= 1'b1;
                            data_q  <= lo_q;
                            busy_q  <= 1'b0;
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                        end else if (at_top) begin
                            dir_q   <= DIR_DOWN;
                            state_q <= ST_DOWN;
                        end
                    end

                    ST_DOWN: begin
                        if (mismatch) begin
                            state_q <= ST_IDLE;
                            load_q  <= 1'b1;
                            data_q  <= lo_q;
                            busy_q  <= 1'b0;
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                        end else if (at_bottom) begin
                            if (rem_q > SWEEP_W'(1)) begin
                                rem_q   <= rem_q - SWEEP_W'(1);
                                dir_q   <= DIR_UP;
                                state_q <= ST_UP;
                            end else begin
                                // Counter lands on lo this edge; hold it there.
                                state_q <= ST_IDLE;
                                load_q  <= 1'b1;
                                data_q  <= lo_q;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end
                    end

                    default: begin
                        state_q <= ST_IDLE;
                        load_q  <= 1'b1;
                        data_q  <= lo_q;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;
    assign bus.cnt_load    = load_q;
    assign bus.cnt_data    = data_q;
    assign bus.cnt_up_down = dir_q;
    // The wrap point is a fixed property of the attached counter.
    assign bus.cnt_wrap    = WRAP;

endmodule
